hex_pe_ctrl: RTL and testbench

Sequencing controller for one 16-lane Hex_PE dot-product/accumulate unit. It pulls 16-element IFM/weight beats from an upstream buffer through a valid/ready handshake and gates PE inputs to zero on bubbles. It generates `PE_reset` and `PE_finish` aligned to the PE's 4-stage adder-tree latency, so each output pixel accumulates exactly `cfg_chunks` beats. It sits between the IFM/weight buffers and the PE in the cluster and reports job completion to the layer controller.

---
 rtl/hex_pe_pkg.sv | 21 ++
 rtl/hex_pe_ctrl_if.sv | 21 ++
 rtl/hex_pe_tag_pipe.sv | 26 ++
 rtl/hex_pe_ctrl.sv | 113 +++++++++++
 tb/tb_hex_pe_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/hex_pe_pkg.sv
// Shared constants and types for the Hex_PE sequencing controller.
package hex_pe_pkg;

   localparam int unsigned PIPE_LAT = 4;
   localparam int unsigned CNT_W    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_e;

   // Per-beat tag travelling alongside the PE adder tree.
   typedef struct packed {
      logic             first;
      logic             last;
      logic             is_final;
      logic [CNT_W-1:0] idx;
   } pe_tag_t;

endpackage

// File: rtl/hex_pe_ctrl_if.sv
// Upstream beat handshake plus PE control strobes of one Hex_PE lane group.
interface hex_pe_ctrl_if;

   logic                          src_valid;
   logic                          src_ready;
   logic                          pe_gate;
   logic                          pe_reset;
   logic                          pe_finish;
   logic [hex_pe_pkg::CNT_W-1:0]  ofm_idx;

   modport master (
      input  src_valid,
      output src_ready, pe_gate, pe_reset, pe_finish, ofm_idx
   );

   modport slave (
      output src_valid,
      input  src_ready, pe_gate, pe_reset, pe_finish, ofm_idx
   );

endinterface

// File: rtl/hex_pe_tag_pipe.sv
// Fixed-depth tag delay line matching the PE adder-tree latency.
module hex_pe_tag_pipe
   import hex_pe_pkg::*;
#(
   parameter int unsigned DEPTH = PIPE_LAT
) (
   input  logic    clk,
   input  logic    reset_n,
   input  pe_tag_t tag_in,
   output pe_tag_t tag_out
);

   pe_tag_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tag_in;
         for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/hex_pe_ctrl.sv
// Sequencer for one 16-lane Hex_PE: pulls beats, tags them, and times
// PE_reset/PE_finish against the adder-tree latency.
module hex_pe_ctrl
   import hex_pe_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_chunks,
   input  logic [CNT_W-1:0] cfg_outputs,
   hex_pe_ctrl_if.master    pe_bus,
   output logic             busy,
   output logic             done
);

   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] chunks_q, chunks_d;
   logic [CNT_W-1:0] outputs_q, outputs_d;
   logic [CNT_W-1:0] chunk_cnt_q, chunk_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             src_ready_q, busy_q, done_q;
   logic             fire_c, is_last_c, is_final_c, zero_start_c;
   pe_tag_t          tag_in_c, tag_out;

   assign fire_c     = pe_bus.src_valid & src_ready_q;
   assign is_last_c  = (chunk_cnt_q == chunks_q - CNT_W'(1));
   assign is_final_c = is_last_c && (out_cnt_q == outputs_q - CNT_W'(1));

   // Next-state, counter and tag generation.
   always_comb begin
      state_d      = state_q;
      chunks_d     = chunks_q;
      outputs_d    = outputs_q;
      chunk_cnt_d  = chunk_cnt_q;
      out_cnt_d    = out_cnt_q;
      zero_start_c = 1'b0;
      tag_in_c     = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if ((cfg_chunks != '0) && (cfg_outputs != '0)) begin
                  chunks_d    = cfg_chunks;
                  outputs_d   = cfg_outputs;
                  chunk_cnt_d = '0;
                  out_cnt_d   = '0;
                  state_d     = RUN;
               end else begin
                  zero_start_c = 1'b1;
               end
            end
         end
         RUN: begin
            if (fire_c) begin
               tag_in_c.first    = (chunk_cnt_q == '0);
               tag_in_c.last     = is_last_c;
               tag_in_c.is_final = is_final_c;
               tag_in_c.idx      = out_cnt_q;
               if (is_last_c) begin
                  chunk_cnt_d = '0;
                  out_cnt_d   = out_cnt_q + CNT_W'(1);
               end else begin
                  chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
               end
               if (is_final_c) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (tag_out.is_final) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         chunks_q    <= '0;
         outputs_q   <= '0;
         chunk_cnt_q <= '0;
         out_cnt_q   <= '0;
         src_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         chunks_q    <= chunks_d;
         outputs_q   <= outputs_d;
         chunk_cnt_q <= chunk_cnt_d;
         out_cnt_q   <= out_cnt_d;
         src_ready_q <= (state_d == RUN);
         busy_q      <= (state_d != IDLE);
         done_q      <= tag_out.is_final | zero_start_c;
      end
   end

   hex_pe_tag_pipe #(.DEPTH(PIPE_LAT)) u_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in_c),
      .tag_out (tag_out)
   );

   // Bubbles carry an all-zero tag, so the strobes stay low for them.
   assign pe_bus.src_ready = src_ready_q;
   assign pe_bus.pe_gate   = fire_c;
   assign pe_bus.pe_reset  = tag_out.first;
   assign pe_bus.pe_finish = tag_out.last;
   assign pe_bus.ofm_idx   = tag_out.idx;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_hex_pe_ctrl.sv
// Directed and random checks of hex_pe_ctrl against a beat-numbering model.
module tb_hex_pe_ctrl;
   import hex_pe_pkg::*;

   localparam int MAXC = 4096;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] cfg_chunks = '0;
   logic [CNT_W-1:0] cfg_outputs = '0;
   logic             busy, done;

   hex_pe_ctrl_if bus ();

   hex_pe_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .cfg_chunks  (cfg_chunks),
      .cfg_outputs (cfg_outputs),
      .pe_bus      (bus),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Expected strobes scheduled by absolute cycle number.
   bit ev_first [MAXC];
   bit ev_last  [MAXC];
   bit ev_done  [MAXC];
   int ev_idx   [MAXC];

   int cyc = 0;
   bit m_run = 0, m_busy = 0;
   int m_chunks = 1, m_total = 0, m_fired = 0;
   int checks = 0, errors = 0;
   int obs_finish = 0, obs_done = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_future();
      for (int i = cyc; i < MAXC; i++) begin
         ev_first[i] = 0; ev_last[i] = 0; ev_done[i] = 0; ev_idx[i] = 0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"},  32'(bus.src_ready), 32'd0);
      chk({tag, "_gate"},   32'(bus.pe_gate),   32'd0);
      chk({tag, "_reset"},  32'(bus.pe_reset),  32'd0);
      chk({tag, "_finish"}, 32'(bus.pe_finish), 32'd0);
      chk({tag, "_idx"},    32'(bus.ofm_idx),   32'd0);
      chk({tag, "_busy"},   32'(busy),          32'd0);
      chk({tag, "_done"},   32'(done),          32'd0);
   endtask

   // One clock cycle: drive inputs, check handshake, advance, check strobes.
   task automatic step(input bit sv, input bit st, input int ch, input int ou);
      int n, c;
      bus.src_valid = sv;
      start = st;
      if (st) begin
         cfg_chunks  = CNT_W'(ch);
         cfg_outputs = CNT_W'(ou);
      end
      #1;
      chk("src_ready", 32'(bus.src_ready), 32'(m_run));
      chk("pe_gate",   32'(bus.pe_gate),   32'(sv & m_run));
      if (sv && m_run) begin
         n = m_fired;
         c = n % m_chunks;
         ev_first[cyc + PIPE_LAT] = (c == 0);
         ev_last[cyc + PIPE_LAT]  = (c == m_chunks - 1);
         ev_idx[cyc + PIPE_LAT]   = n / m_chunks;
         if (n == m_total - 1) begin
            ev_done[cyc + PIPE_LAT + 1] = 1;
            m_run = 0;
         end
         m_fired++;
      end
      if (st && !m_busy) begin
         if (ch != 0 && ou != 0) begin
            m_run = 1; m_busy = 1; m_chunks = ch; m_total = ch * ou; m_fired = 0;
         end else begin
            ev_done[cyc + 1] = 1;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (ev_done[cyc]) m_busy = 0;
      chk("pe_reset",  32'(bus.pe_reset),  32'(ev_first[cyc]));
      chk("pe_finish", 32'(bus.pe_finish), 32'(ev_last[cyc]));
      chk("done",      32'(done),          32'(ev_done[cyc]));
      chk("busy",      32'(busy),          32'(m_busy));
      if (ev_last[cyc]) chk("ofm_idx", 32'(bus.ofm_idx), 32'(ev_idx[cyc]));
      if (bus.pe_finish === 1'b1) obs_finish++;
      if (done === 1'b1) obs_done++;
   endtask

   initial begin
      int guard;
      bus.src_valid = 1'b0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Single-beat job: reset and finish coincide, done one cycle later.
      step(1, 1, 1, 1);
      repeat (8) step(1, 0, 0, 0);

      // Two-cycle stall after beat 2 delays the finish by two cycles.
      step(0, 1, 4, 1);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      repeat (7) step(1, 0, 0, 0);

      // Back-to-back pixels.
      step(1, 1, 3, 2);
      repeat (12) step(1, 0, 0, 0);

      // Zero-sized configs complete immediately without issuing beats.
      step(1, 1, 0, 5);
      repeat (3) step(1, 0, 0, 0);
      step(1, 1, 5, 0);
      repeat (3) step(1, 0, 0, 0);

      // A start during RUN must not disturb the running job.
      step(1, 1, 2, 3);
      step(1, 0, 0, 0);
      step(1, 1, 7, 7);
      repeat (12) step(1, 0, 0, 0);

      // Asynchronous reset in the middle of the second pixel.
      step(1, 1, 8, 3);
      repeat (10) step(1, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      m_run = 0; m_busy = 0;
      clear_future();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      reset_n = 1'b1;
      step(1, 1, 8, 3);
      repeat (32) step(1, 0, 0, 0);

      // Random valid with 50% density, 5 chunks x 10 outputs.
      obs_finish = 0;
      obs_done   = 0;
      step(0, 1, 5, 10);
      guard = 0;
      while (m_busy && guard < 400) begin
         step(1'($urandom_range(0, 1)), 0, 0, 0);
         guard++;
      end
      chk("random_timeout", 32'(m_busy), 32'd0);
      repeat (3) step(1'($urandom_range(0, 1)), 0, 0, 0);
      chk("random_finish_count", 32'(obs_finish), 32'd10);
      chk("random_done_count",   32'(obs_done),   32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
